// File: rtl/ddr3_pkg.sv
// Shared types, DDR3 pin encodings and address decode for the command issuer.
package ddr3_pkg;

  localparam int DDR3_ADDR_W = 17;
  localparam int DDR3_BANK_W = 3;
  localparam int DDR3_ROW_W  = 16;
  localparam int DDR3_COL_W  = 10;
  localparam int DDR3_RA_W   = DDR3_ADDR_W - DDR3_COL_W - DDR3_BANK_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_CAS
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] PIN_NOP   = 4'b0111;
  localparam logic [3:0] PIN_ACT   = 4'b0011;
  localparam logic [3:0] PIN_RD    = 4'b0101;
  localparam logic [3:0] PIN_WR    = 4'b0100;
  localparam logic [3:0] PIN_PRE   = 4'b0010;
  localparam logic [3:0] PIN_DESEL = 4'b1111;

  typedef struct packed {
    logic [DDR3_ROW_W-1:0]  row;
    logic [DDR3_BANK_W-1:0] bank;
    logic [DDR3_COL_W-1:0]  col;
  } addr_fields_t;

  function automatic addr_fields_t decode_addr(input logic [DDR3_ADDR_W-1:0] a);
    addr_fields_t f;
    f.col  = a[DDR3_COL_W-1:0];
    f.bank = a[DDR3_COL_W +: DDR3_BANK_W];
    f.row  = DDR3_ROW_W'(a[DDR3_ADDR_W-1 -: DDR3_RA_W]);
    return f;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] c);
    return (c == 8'd0) ? 8'd0 : c - 8'd1;
  endfunction

  // A counter loaded on the cycle a command hits the pins: a command issued
  // now lands next cycle, so it is legal once the count is at most 1.
  function automatic logic cnt_done(input logic [7:0] c);
    return c <= 8'd1;
  endfunction

  // Wait states hand over one cycle before the issuing state, hence one more.
  function automatic logic cnt_near(input logic [7:0] c);
    return c <= 8'd2;
  endfunction

endpackage

// File: rtl/ddr3_bank_tracker.sv
// Per-bank open-row bookkeeping with tRAS and tWR countdowns gating precharge.
module ddr3_bank_tracker
  import ddr3_pkg::*;
#(
  parameter int BANK_WIDTH = DDR3_BANK_W,
  parameter int ROW_WIDTH  = DDR3_ROW_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      act,
  input  logic                      wr,
  input  logic                      pre,
  input  logic [BANK_WIDTH-1:0]     cmd_bank,
  input  logic [ROW_WIDTH-1:0]      act_row,
  input  logic [7:0]                t_ras,
  input  logic [7:0]                t_wr,
  input  logic [BANK_WIDTH-1:0]     q_bank,
  input  logic [ROW_WIDTH-1:0]      q_row,
  output logic                      q_hit,
  output logic                      q_open,
  output logic                      q_pre_ok,
  output logic [2**BANK_WIDTH-1:0]  bank_open
);

  localparam int NUM_BANKS = 2**BANK_WIDTH;

  logic [NUM_BANKS-1:0] open_q, open_d;
  logic [ROW_WIDTH-1:0] row_q  [NUM_BANKS];
  logic [ROW_WIDTH-1:0] row_d  [NUM_BANKS];
  logic [7:0]           tras_q [NUM_BANKS];
  logic [7:0]           tras_d [NUM_BANKS];
  logic [7:0]           twr_q  [NUM_BANKS];
  logic [7:0]           twr_d  [NUM_BANKS];

  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      tras_d[b] = sat_dec(tras_q[b]);
      twr_d[b]  = sat_dec(twr_q[b]);
    end
    if (act) begin
      open_d[cmd_bank] = 1'b1;
      row_d[cmd_bank]  = act_row;
      tras_d[cmd_bank] = t_ras;
    end
    if (wr) begin
      twr_d[cmd_bank] = t_wr;
    end
    if (pre) begin
      open_d[cmd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      open_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        row_q[b]  <= '0;
        tras_q[b] <= '0;
        twr_q[b]  <= '0;
      end
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      tras_q <= tras_d;
      twr_q  <= twr_d;
    end
  end

  assign q_open    = open_q[q_bank];
  assign q_hit     = q_open && (row_q[q_bank] == q_row);
  assign q_pre_ok  = cnt_done(tras_q[q_bank]) && cnt_done(twr_q[q_bank]);
  assign bank_open = open_q;

endmodule

// File: rtl/ddr3_cmd_issuer.sv
// Accepts one read/write request at a time and sequences PRE/ACT/RD/WR onto
// registered DDR3 command pins under an open-page policy.
//
// state      | meaning
// S_IDLE     | ready for a request; decides hit / miss / closed
// S_PRE      | wait for tRAS/tWR of the bank, then precharge it
// S_WAIT_RP  | precharge-to-activate spacing
// S_ACT      | activate the requested row
// S_WAIT_RCD | activate-to-column spacing
// S_CAS      | wait for tCCD, then issue the read or write
module ddr3_cmd_issuer
  import ddr3_pkg::*;
#(
  parameter int ADDR_WIDTH = DDR3_ADDR_W,
  parameter int BANK_WIDTH = DDR3_BANK_W,
  parameter int ROW_WIDTH  = DDR3_ROW_W,
  parameter int COL_WIDTH  = DDR3_COL_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic                      cmd_valid,
  input  logic                      cmd_write,
  input  logic                      cmd_read,
  output logic                      cmd_ready,
  input  logic [7:0]                tRCD,
  input  logic [7:0]                tRP,
  input  logic [7:0]                tRAS,
  input  logic [7:0]                tWR,
  input  logic [3:0]                tCCD,
  output logic                      ddr_cs_n,
  output logic                      ddr_ras_n,
  output logic                      ddr_cas_n,
  output logic                      ddr_we_n,
  output logic [BANK_WIDTH-1:0]     ddr_ba,
  output logic [ROW_WIDTH-1:0]      ddr_addr,
  output logic [2**BANK_WIDTH-1:0]  bank_open,
  output logic                      cmd_err
);

  state_t                state_q, state_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic                  write_q, write_d;
  logic [3:0]            pins_q, pins_d;
  logic [BANK_WIDTH-1:0] ba_q, ba_d;
  logic [ROW_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]            wait_q, wait_d;
  logic [7:0]            tccd_q, tccd_d;
  logic                  err_q, err_d;

  addr_fields_t          req_f;
  logic                  idle, accept, legal;
  logic                  act_s, wr_s, pre_s;
  logic [BANK_WIDTH-1:0] q_bank;
  logic [ROW_WIDTH-1:0]  q_row;
  logic                  q_hit, q_open, q_pre_ok;

  assign req_f     = decode_addr(cmd_addr);
  assign idle      = (state_q == S_IDLE);
  assign cmd_ready = idle && reset_n;
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = cmd_read ^ cmd_write;

  // In IDLE the tracker is asked about the incoming request, afterwards about the latched one.
  assign q_bank = idle ? req_f.bank : bank_q;
  assign q_row  = idle ? req_f.row  : row_q;

  ddr3_bank_tracker #(
    .BANK_WIDTH (BANK_WIDTH),
    .ROW_WIDTH  (ROW_WIDTH)
  ) u_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .act       (act_s),
    .wr        (wr_s),
    .pre       (pre_s),
    .cmd_bank  (bank_q),
    .act_row   (row_q),
    .t_ras     (tRAS),
    .t_wr      (tWR),
    .q_bank    (q_bank),
    .q_row     (q_row),
    .q_hit     (q_hit),
    .q_open    (q_open),
    .q_pre_ok  (q_pre_ok),
    .bank_open (bank_open)
  );

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    write_d = write_q;
    pins_d  = PIN_NOP;
    ba_d    = ba_q;
    addr_d  = addr_q;
    wait_d  = sat_dec(wait_q);
    tccd_d  = sat_dec(tccd_q);
    err_d   = 1'b0;
    act_s   = 1'b0;
    wr_s    = 1'b0;
    pre_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            bank_d  = req_f.bank;
            row_d   = req_f.row;
            col_d   = req_f.col;
            write_d = cmd_write;
            if (q_hit)       state_d = S_CAS;
            else if (q_open) state_d = S_PRE;
            else             state_d = S_ACT;
          end
        end
      end
      S_PRE: begin
        if (q_pre_ok) begin
          pins_d  = PIN_PRE;
          ba_d    = bank_q;
          addr_d  = '0;
          pre_s   = 1'b1;
          wait_d  = tRP;
          state_d = S_WAIT_RP;
        end
      end
      S_WAIT_RP: begin
        if (cnt_near(wait_q)) state_d = S_ACT;
      end
      S_ACT: begin
        pins_d  = PIN_ACT;
        ba_d    = bank_q;
        addr_d  = row_q;
        act_s   = 1'b1;
        wait_d  = tRCD;
        state_d = S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        if (cnt_near(wait_q)) state_d = S_CAS;
      end
      S_CAS: begin
        if (cnt_done(tccd_q)) begin
          pins_d  = write_q ? PIN_WR : PIN_RD;
          ba_d    = bank_q;
          addr_d  = ROW_WIDTH'(col_q);
          wr_s    = write_q;
          tccd_d  = {4'b0000, tCCD};
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      write_q <= 1'b0;
      pins_q  <= PIN_DESEL;
      ba_q    <= '0;
      addr_q  <= '0;
      wait_q  <= '0;
      tccd_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      write_q <= write_d;
      pins_q  <= pins_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      tccd_q  <= tccd_d;
      err_q   <= err_d;
    end
  end

  assign {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = pins_q;
  assign ddr_ba   = ba_q;
  assign ddr_addr = addr_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_ddr3_cmd_issuer.sv
// Scoreboard bench for ddr3_cmd_issuer: a timestamp-based reference model
// predicts every pin command, which a negedge monitor pops and compares.
module tb_ddr3_cmd_issuer;

  localparam logic [3:0] P_NOP = 4'b0111;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_DES = 4'b1111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [16:0] cmd_addr = '0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_read = 1'b0;
  logic [7:0]  tRCD, tRP, tRAS, tWR;
  logic [3:0]  tCCD;
  wire         cmd_ready;
  wire         ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n;
  wire [2:0]   ddr_ba;
  wire [15:0]  ddr_addr;
  wire [7:0]   bank_open;
  wire         cmd_err;

  ddr3_cmd_issuer dut (
    .clk(clk), .reset_n(reset_n), .cmd_addr(cmd_addr), .cmd_valid(cmd_valid),
    .cmd_write(cmd_write), .cmd_read(cmd_read), .cmd_ready(cmd_ready),
    .tRCD(tRCD), .tRP(tRP), .tRAS(tRAS), .tWR(tWR), .tCCD(tCCD),
    .ddr_cs_n(ddr_cs_n), .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n), .ddr_we_n(ddr_we_n),
    .ddr_ba(ddr_ba), .ddr_addr(ddr_addr), .bank_open(bank_open), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] pins;
    logic [2:0] ba;
    logic [15:0] addr;
    logic [7:0] open;
  } exp_t;

  exp_t sb_q[$];
  int   err_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model: per-bank row state plus timestamps of the last commands.
  bit m_open[8];
  int m_row[8];
  int m_last_act[8];
  int m_last_wr[8];
  int m_last_cas;
  int m_ready;

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] open_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_open[i];
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic abort(input string what);
    errors++;
    $display("FAIL %s: timed out at edge %0d", what, cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_open[i] = 1'b0;
      m_row[i] = 0;
      m_last_act[i] = -1000;
      m_last_wr[i] = -1000;
    end
    m_last_cas = -1000;
    m_ready = 0;
  endtask

  task automatic model_req(input logic [16:0] a, input bit rd, input bit wr, input int h);
    int bank, row, col, pre, act, cas, t_ccd;
    bank = int'(a[12:10]);
    row  = int'(a[16:13]);
    col  = int'(a[9:0]);
    if (rd == wr) begin
      err_q.push_back(h);
      m_ready = h + 1;
      return;
    end
    t_ccd = mx(1, int'(tCCD));
    if (m_open[bank] && m_row[bank] == row) begin
      cas = mx(h + 1, m_last_cas + t_ccd);
    end else begin
      if (m_open[bank]) begin
        pre = mx(h + 1, mx(m_last_act[bank] + mx(1, int'(tRAS)),
                           m_last_wr[bank] + mx(1, int'(tWR))));
        m_open[bank] = 1'b0;
        sb_q.push_back('{at: pre, pins: P_PRE, ba: 3'(bank), addr: 16'd0, open: open_vec()});
        act = pre + mx(2, int'(tRP));
      end else begin
        act = h + 1;
      end
      m_open[bank] = 1'b1;
      m_row[bank] = row;
      m_last_act[bank] = act;
      sb_q.push_back('{at: act, pins: P_ACT, ba: 3'(bank), addr: 16'(row), open: open_vec()});
      cas = mx(act + mx(2, int'(tRCD)), m_last_cas + t_ccd);
    end
    sb_q.push_back('{at: cas, pins: (wr ? P_WR : P_RD), ba: 3'(bank), addr: 16'(col), open: open_vec()});
    m_last_cas = cas;
    if (wr) m_last_wr[bank] = cas;
    m_ready = cas + 1;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic issue(input logic [16:0] a, input bit rd, input bit wr);
    int p, h, n;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_read  = rd;
    cmd_write = wr;
    p = cyc + 1;
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) abort("handshake");
    h = cyc + 1;
    chk("handshake_edge", h, mx(p, m_ready));
    model_req(a, rd, wr, h);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || err_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || err_q.size() != 0) abort("drain");
    repeat (60) @(negedge clk);
  endtask

  task automatic rand_phase(input int count);
    logic [16:0] a;
    int r;
    bit rd, wr;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      a = {3'b000, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 10'($urandom)};
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rd = 1'($urandom_range(0, 1));
        wr = rd;
      end else begin
        rd = (r < 6);
        wr = !rd;
      end
      issue(a, rd, wr);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] p;
    exp_t e;
    if (mon_en && reset_n) begin
      p = {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n};
      if (p != P_NOP && p != P_DES) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got pins %b ba %0d addr %0h at edge %0d, expected none",
                   p, ddr_ba, ddr_addr, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("cmd_edge", cyc, e.at);
          chk("cmd_pins", p, e.pins);
          chk("cmd_ba", ddr_ba, e.ba);
          chk("cmd_addr", ddr_addr, e.addr);
          chk("bank_open", bank_open, e.open);
        end
      end
      if (cmd_err) begin
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: got cmd_err 1 at edge %0d, expected 0", cyc);
        end else begin
          chk("err_edge", cyc, err_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    tRCD = 8'd12; tRP = 8'd12; tRAS = 8'd36; tWR = 8'd12; tCCD = 4'd4;
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pins", {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}, P_DES);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_bank_open", bank_open, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_ba", ddr_ba, 0);
    chk("rst_addr", ddr_addr, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_ready", cmd_ready, 1);
    @(negedge clk);
    chk("rel_pins", {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}, P_NOP);
    mon_en = 1'b1;

    // Directed walk-through with default timing.
    issue(17'h00405, 1'b1, 1'b0);
    issue(17'h00406, 1'b1, 1'b0);
    issue(17'h00407, 1'b1, 1'b0);
    issue(17'h02405, 1'b1, 1'b0);
    issue(17'h00805, 1'b0, 1'b1);
    issue(17'h02805, 1'b1, 1'b0);
    issue(17'h00405, 1'b1, 1'b1);
    issue(17'h00405, 1'b0, 1'b0);
    issue(17'h00405, 1'b0, 1'b1);
    drain();

    // Reset while waiting tRCD on a closed bank (bank 5).
    issue(17'h01405, 1'b1, 1'b0);
    n = 0;
    while (sb_q.size() != 1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 1) abort("act_before_reset");
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_pins", {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}, P_DES);
    chk("midrst_bank_open", bank_open, 0);
    chk("midrst_ready", cmd_ready, 0);
    sb_q.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_rel_ready", cmd_ready, 1);
    repeat (40) @(negedge clk);
    chk("midrst_bank_open_after", bank_open, 0);

    rand_phase(60);
    drain();

    tRCD = 8'($urandom_range(2, 15));
    tRP  = 8'($urandom_range(2, 15));
    tRAS = 8'($urandom_range(2, 40));
    tWR  = 8'($urandom_range(1, 20));
    tCCD = 4'($urandom_range(1, 8));
    rand_phase(60);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
